// File: rtl/chunked_magnitude_comparator.sv
// Sequential magnitude comparator: walks WIDTH-bit operands CHUNK bits per cycle, MSB chunk first.
// Build option CMP_SIGNED_EN enables the two's-complement sign check on the first chunk.
module chunked_magnitude_comparator #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             GT,
    output logic             LT,
    output logic             EQ
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

    typedef enum logic {IDLE, COMPARE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [31:0]      base;
    logic [CHUNK-1:0] chunk_a, chunk_b;
    logic             accept;
    logic             sign_decide;
    logic             decided, res_gt, res_lt, res_eq;

    assign accept  = (state_q == IDLE) && start;
    assign base    = 32'(idx_q) * CHUNK;
    assign a_sh    = a_q >> base;
    assign b_sh    = b_q >> base;
    assign chunk_a = a_sh[CHUNK-1:0];
    assign chunk_b = b_sh[CHUNK-1:0];

`ifdef CMP_SIGNED_EN
    logic sgn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn_q <= 1'b0;
        end else if (accept) begin
            sgn_q <= signed_mode;
        end
    end

    // Differing sign bits decide at once; equal signs leave unsigned order intact.
    assign sign_decide = sgn_q && (idx_q == IDX_TOP) && (a_q[WIDTH-1] != b_q[WIDTH-1]);
`else
    logic unused_signed;
    assign unused_signed = signed_mode;
    assign sign_decide   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        decided = 1'b0;
        res_gt  = 1'b0;
        res_lt  = 1'b0;
        res_eq  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COMPARE;
                    idx_d   = IDX_TOP;
                end
            end
            COMPARE: begin
                if (sign_decide) begin
                    decided = 1'b1;
                    res_lt  = a_q[WIDTH-1];
                    res_gt  = ~a_q[WIDTH-1];
                end else if (chunk_a != chunk_b) begin
                    decided = 1'b1;
                    res_gt  = chunk_a > chunk_b;
                    res_lt  = chunk_a < chunk_b;
                end else if (idx_q == '0) begin
                    decided = 1'b1;
                    res_eq  = 1'b1;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
                if (decided) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            done    <= 1'b0;
            GT      <= 1'b0;
            LT      <= 1'b0;
            EQ      <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done    <= decided;
            if (accept) begin
                a_q <= A;
                b_q <= B;
            end
            if (decided) begin
                GT <= res_gt;
                LT <= res_lt;
                EQ <= res_eq;
            end
        end
    end

    assign busy = (state_q == COMPARE);

endmodule

// File: tb/tb_chunked_magnitude_comparator.sv
// Scoreboard bench for chunked_magnitude_comparator (WIDTH=8, CHUNK=2): directed vectors
// plus a model-checked sweep, with a monitor checking result, latency and busy length on done.
module tb_chunked_magnitude_comparator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       signed_mode;
    logic       busy, done, gt, lt, eq;

    typedef struct {
        logic gt;
        logic lt;
        logic eq;
        int   k;
        int   done_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   busy_run = 0;

    chunked_magnitude_comparator #(
        .WIDTH(8),
        .CHUNK(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .A          (a),
        .B          (b),
        .signed_mode(signed_mode),
        .busy       (busy),
        .done       (done),
        .GT         (gt),
        .LT         (lt),
        .EQ         (eq)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input logic g, input logic l, input logic e, input int k);
        exp_t r;
        r.gt = g;
        r.lt = l;
        r.eq = e;
        r.k = k;
        r.done_cyc = 0;
        return r;
    endfunction

    // Behavioural reference: whole-word compare, latency from the first differing chunk.
    function automatic exp_t ref_cmp(input logic [7:0] av, input logic [7:0] bv, input logic s);
        exp_t r;
        logic sg;
        logic found;
        r.k = 4;
        found = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!found && (av[i*2 +: 2] != bv[i*2 +: 2])) begin
                r.k = 4 - i;
                found = 1'b1;
            end
        end
`ifdef CMP_SIGNED_EN
        sg = s;
        if (s && (av[7] != bv[7])) r.k = 1;
`else
        sg = 1'b0;
        if (s) sg = 1'b0;
`endif
        if (sg) begin
            r.gt = $signed(av) > $signed(bv);
            r.lt = $signed(av) < $signed(bv);
        end else begin
            r.gt = av > bv;
            r.lt = av < bv;
        end
        r.eq = (av == bv);
        r.done_cyc = 0;
        return r;
    endfunction

    // Called at a negedge; the next posedge is the accepting edge.
    task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic s,
                         input exp_t e);
        exp_t x;
        x = e;
        a = av;
        b = bv;
        signed_mode = s;
        start = 1'b1;
        x.done_cyc = cyc + 1 + e.k;
        exp_q.push_back(x);
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        signed_mode = 1'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles (cycle %0d)", n, cyc);
            exp_q.delete();
        end
    endtask

    task automatic run(input logic [7:0] av, input logic [7:0] bv, input logic s,
                       input exp_t e);
        issue(av, bv, s, e);
        wait_done();
    endtask

    initial forever begin
        @(negedge clk);
        if (rst) begin
            busy_run = 0;
        end else begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result_gt_lt_eq", {29'd0, gt, lt, eq},
                          {29'd0, mon_e.gt, mon_e.lt, mon_e.eq});
                    check("done_cycle", cyc, mon_e.done_cyc);
                    check("busy_cycles", busy_run, mon_e.k);
                    check("busy_low_at_done", {31'd0, busy}, 32'd0);
                end
                busy_run = 0;
            end
            if (busy) busy_run++;
        end
    end

    logic [7:0] vals [16];

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        signed_mode = 1'b0;
        vals = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7E, 8'h7F, 8'h80, 8'h81,
                 8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0};
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", {27'd0, busy, done, gt, lt, eq}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, hand-computed.
        run(8'h5A, 8'h5A, 1'b0, mk(1'b0, 1'b0, 1'b1, 4));
        run(8'h80, 8'h7F, 1'b0, mk(1'b1, 1'b0, 1'b0, 1));
`ifdef CMP_SIGNED_EN
        run(8'h80, 8'h7F, 1'b1, mk(1'b0, 1'b1, 1'b0, 1));
        run(8'h00, 8'hFF, 1'b1, mk(1'b1, 1'b0, 1'b0, 1));
`else
        run(8'h80, 8'h7F, 1'b1, mk(1'b1, 1'b0, 1'b0, 1));
        run(8'h00, 8'hFF, 1'b1, mk(1'b0, 1'b1, 1'b0, 1));
`endif
        run(8'h13, 8'h12, 1'b0, mk(1'b1, 1'b0, 1'b0, 4));
        run(8'hFE, 8'hFD, 1'b1, mk(1'b1, 1'b0, 1'b0, 4));
        run(8'h40, 8'h80, 1'b0, mk(1'b0, 1'b1, 1'b0, 1));
        run(8'h24, 8'h28, 1'b0, mk(1'b0, 1'b1, 1'b0, 3));

        // Start while busy is ignored, not queued.
        issue(8'h01, 8'h02, 1'b0, mk(1'b0, 1'b1, 1'b0, 4));
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);
        check("ignored_start_no_busy", {31'd0, busy}, 32'd0);

        // Reset in the 2nd COMPARE cycle aborts with no done and clears the held result.
        a = 8'h13;
        b = 8'h12;
        signed_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", {29'd0, gt, lt, eq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_done_after_abort", {30'd0, busy, done}, 32'd0);
        end

        // Back-to-back sweep against the reference model.
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    run(vals[i], vals[j], 1'(m), ref_cmp(vals[i], vals[j], 1'(m)));
                end
            end
        end
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra, rb;
            logic       rs;
            ra = 8'($urandom);
            rb = (n % 4 == 0) ? ra ^ 8'(1 << (n % 8)) : 8'($urandom);
            rs = 1'($urandom);
            run(ra, rb, rs, ref_cmp(ra, rb, rs));
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
